// File: rtl/uart_line_arbiter_if.sv
// Producer-side and UART-side signals of the line arbiter, bundled as one port.
// Handshake: a producer byte moves on a posedge where req_en[i] & !req_busy[i]; a UART byte moves on a posedge where output_en & !output_busy.
interface uart_line_arbiter_if #(
    parameter int N = 2
);
    localparam int GW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]   req_en;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_busy;
    logic           output_busy;
    logic           output_en;
    logic [7:0]     output_data;
    logic           grant_valid;
    logic [GW-1:0]  grant_id;

    modport slave (
        input  req_en,
        input  req_data,
        input  output_busy,
        output req_busy,
        output output_en,
        output output_data,
        output grant_valid,
        output grant_id
    );

    modport master (
        output req_en,
        output req_data,
        output output_busy,
        input  req_busy,
        input  output_en,
        input  output_data,
        input  grant_valid,
        input  grant_id
    );
endinterface

// File: rtl/uart_line_arbiter.sv
// Round-robin arbiter that hands the UART TX path to one producer per text line,
// with a one-entry registered output buffer toward the transmitter.
module uart_line_arbiter #(
    parameter int N       = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    uart_line_arbiter_if.slave   bus
);
    localparam int GW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] IDLE_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [7:0] NEWLINE = 8'h0A;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [GW-1:0]  rr_q, rr_d;
    logic [GW-1:0]  grant_q, grant_d;
    logic [CW-1:0]  idle_q, idle_d;
    logic           buf_valid_q;
    logic [7:0]     buf_data_q;

    logic           found;
    logic [GW-1:0]  winner;
    int             idx;
    logic           owner_en;
    logic [7:0]     owner_byte;
    logic           owner_busy;
    logic           accept;
    logic           transfer;
    logic [GW-1:0]  next_ptr;
    logic [N-1:0]   req_busy_c;

    assign owner_en   = bus.req_en[grant_q];
    assign owner_byte = bus.req_data[8*grant_q +: 8];
    // The owner may push whenever the buffer is empty or drains on this same edge.
    assign owner_busy = buf_valid_q & bus.output_busy;
    assign accept     = (state_q == LOCKED) & owner_en & ~owner_busy;
    assign transfer   = buf_valid_q & ~bus.output_busy;
    assign next_ptr   = (int'(grant_q) == N - 1) ? '0 : grant_q + 1'b1;

    // First requester at or after rr_q, wrapping at N (N need not be a power of 2).
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && bus.req_en[idx[GW-1:0]]) begin
                found  = 1'b1;
                winner = idx[GW-1:0];
            end
        end
    end

    always_comb begin
        req_busy_c = '1;
        if (state_q == LOCKED) begin
            req_busy_c[grant_q] = owner_busy;
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        idle_d  = idle_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = LOCKED;
                    grant_d = winner;
                    idle_d  = '0;
                end
            end
            LOCKED: begin
                if (accept) begin
                    idle_d = '0;
                    if (owner_byte == NEWLINE) begin
                        state_d = IDLE;
                        rr_d    = next_ptr;
                    end
                end else if (!owner_en) begin
                    // A silent owner is evicted so one stalled producer cannot hold the UART forever.
                    if ((TIMEOUT != 0) && (idle_q == IDLE_LAST)) begin
                        state_d = IDLE;
                        rr_d    = next_ptr;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= '0;
            grant_q <= '0;
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            idle_q  <= idle_d;
        end
    end

    // Output buffer drains independently of ownership, so bytes leave in acceptance order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid_q <= 1'b0;
            buf_data_q  <= '0;
        end else if (accept) begin
            buf_valid_q <= 1'b1;
            buf_data_q  <= owner_byte;
        end else if (transfer) begin
            buf_valid_q <= 1'b0;
        end
    end

    assign bus.req_busy    = req_busy_c;
    assign bus.output_en   = buf_valid_q;
    assign bus.output_data = buf_data_q;
    assign bus.grant_valid = (state_q == LOCKED);
    assign bus.grant_id    = grant_q;

    grant_in_range: assert property (@(posedge clk) disable iff (!rst_n)
        int'(grant_q) < N);

    output_held_while_busy: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.output_en && bus.output_busy) |=> (bus.output_en && $stable(bus.output_data)));
endmodule

// File: tb/tb_uart_line_arbiter.sv
// Bench for uart_line_arbiter: line-level round-robin reference model feeding a byte scoreboard,
// plus directed latency, timeout, reset and TIMEOUT=0 sequences.
module tb_uart_line_arbiter;
    localparam int NA   = 2;
    localparam int NB   = 3;
    localparam int TO_A = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_line_arbiter_if #(.N(NA)) ia ();
    uart_line_arbiter_if #(.N(NB)) ib ();

    uart_line_arbiter #(.N(NA), .TIMEOUT(TO_A)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
    uart_line_arbiter #(.N(NB), .TIMEOUT(0))    dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [$];
    logic [7:0] src_q [NA][$];
    int gap_cnt [NA];
    int max_gap   = 0;
    int busy_mode = 0;
    int model_rr  = 0;
    logic busy_tog = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: pops the expected UART byte on every predicted transfer.
    logic prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] mon_exp;
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_en", 32'(ia.output_en), 32'd1);
                check("hold_data", 32'(ia.output_data), 32'(prev_data));
            end
            if (ia.grant_valid) begin
                for (int j = 0; j < NA; j++) begin
                    if (j != int'(ia.grant_id)) check("busy_other", 32'(ia.req_busy[j]), 32'd1);
                end
                check("busy_owner", 32'(ia.req_busy[ia.grant_id]), 32'(ia.output_en & ia.output_busy));
            end else begin
                check("busy_idle", 32'(ia.req_busy), 32'({NA{1'b1}}));
            end
            if (ia.output_en && !ia.output_busy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL uart_extra: got %0h expected no byte", ia.output_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("uart_byte", 32'(ia.output_data), 32'(mon_exp));
                end
            end
            prev_stall = ia.output_en && ia.output_busy;
            prev_data  = ia.output_data;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic bit src_empty();
        for (int i = 0; i < NA; i++) if (src_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic load_line(input int r, input string s);
        for (int i = 0; i < s.len(); i++) src_q[r].push_back(s[i]);
    endtask

    // Reference: whole lines leave in round-robin order over requesters that still have lines.
    task automatic model_lines();
        logic [7:0] tmp [NA][$];
        logic [7:0] b;
        int k;
        bit any;
        for (int i = 0; i < NA; i++) tmp[i] = src_q[i];
        forever begin
            any = 1'b0;
            k = 0;
            for (int s = 0; s < NA; s++) begin
                if (!any && tmp[(model_rr + s) % NA].size() != 0) begin
                    any = 1'b1;
                    k = (model_rr + s) % NA;
                end
            end
            if (!any) break;
            do begin
                b = tmp[k].pop_front();
                exp_q.push_back(b);
            end while (b != 8'h0A && tmp[k].size() != 0);
            model_rr = (k + 1) % NA;
        end
    endtask

    task automatic do_cycle();
        logic [7:0] b;
        @(negedge clk);
        case (busy_mode)
            0: ia.output_busy = 1'b0;
            1: ia.output_busy = 1'($urandom_range(0, 1));
            2: begin busy_tog = ~busy_tog; ia.output_busy = busy_tog; end
            default: ia.output_busy = 1'b1;
        endcase
        for (int i = 0; i < NA; i++) begin
            if (gap_cnt[i] > 0) begin
                ia.req_en[i] = 1'b0;
                gap_cnt[i]--;
            end else if (src_q[i].size() != 0) begin
                ia.req_en[i] = 1'b1;
                ia.req_data[8*i +: 8] = src_q[i][0];
            end else begin
                ia.req_en[i] = 1'b0;
            end
        end
        #1;
        for (int i = 0; i < NA; i++) begin
            if (ia.req_en[i] && !ia.req_busy[i]) begin
                b = src_q[i].pop_front();
                gap_cnt[i] = (b == 8'h0A) ? 0 : $urandom_range(0, max_gap);
            end
        end
    endtask

    task automatic run_drain(input int budget, input string name);
        int c = 0;
        while ((!src_empty() || exp_q.size() != 0) && c < budget) begin
            do_cycle();
            c++;
        end
        checks++;
        if (c >= budget) begin
            errors++;
            $display("FAIL %s drain: %0d bytes outstanding, required 0", name, exp_q.size());
        end
        repeat (3) do_cycle();
    endtask

    task automatic wait_src(input int r, input int budget, input string name);
        int c = 0;
        while (src_q[r].size() != 0 && c < budget) begin
            do_cycle();
            c++;
        end
        checks++;
        if (c >= budget) begin
            errors++;
            $display("FAIL %s accept wait: %0d bytes left, required 0", name, src_q[r].size());
        end
    endtask

    task automatic clear_src();
        for (int i = 0; i < NA; i++) begin
            src_q[i].delete();
            gap_cnt[i] = 0;
        end
        ia.req_en = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_src();
        model_rr = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int cnt;
        int len;
        int nl;
        ia.req_en = '0; ia.req_data = '0; ia.output_busy = 1'b0;
        ib.req_en = '0; ib.req_data = '0; ib.output_busy = 1'b0;
        for (int i = 0; i < NA; i++) gap_cnt[i] = 0;

        // Reset values
        #1;
        check("rst_oen", 32'(ia.output_en), 32'd0);
        check("rst_odata", 32'(ia.output_data), 32'd0);
        check("rst_busy", 32'(ia.req_busy), 32'({NA{1'b1}}));
        check("rst_gv", 32'(ia.grant_valid), 32'd0);
        check("rst_gid", 32'(ia.grant_id), 32'd0);
        check("rst_b_busy", 32'(ib.req_busy), 32'({NB{1'b1}}));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // One line, no backpressure: arbitration and output latency
        load_line(0, "12\n");
        model_lines();
        for (int c = 1; c <= 5; c++) begin
            do_cycle();
            if (c == 2) begin
                check("lat_gv", 32'(ia.grant_valid), 32'd1);
                check("lat_oen_before", 32'(ia.output_en), 32'd0);
            end
            if (c == 3) check("lat_oen_first", 32'(ia.output_en), 32'd1);
            if (c == 4) check("lat_gv_midline", 32'(ia.grant_valid), 32'd1);
            if (c == 5) check("line_end_gv", 32'(ia.grant_valid), 32'd0);
        end
        run_drain(50, "latency");

        // Two contending requesters from reset
        do_reset();
        load_line(0, "A\nA\n");
        load_line(1, "B\nB\n");
        model_lines();
        run_drain(100, "round_robin");

        // Alternating UART backpressure
        busy_mode = 2;
        load_line(0, "345\n");
        model_lines();
        run_drain(100, "toggle_busy");
        busy_mode = 0;

        // Mid-line timeout hands the line to the waiting requester
        do_reset();
        load_line(0, "9");
        load_line(1, "B\n");
        exp_q.push_back(8'h39);
        exp_q.push_back(8'h42);
        exp_q.push_back(8'h0A);
        model_rr = 0;
        wait_src(0, 20, "timeout");
        cnt = 0;
        do begin
            do_cycle();
            cnt++;
        end while (ia.grant_valid && cnt < 40);
        check("timeout_release_cycles", 32'(cnt), 32'(TO_A + 1));
        cnt = 0;
        while (!ia.grant_valid && cnt < 10) begin
            do_cycle();
            cnt++;
        end
        check("timeout_next_gv", 32'(ia.grant_valid), 32'd1);
        check("timeout_next_owner", 32'(ia.grant_id), 32'd1);
        run_drain(100, "timeout");

        // Reset while a byte sits in the buffer behind a busy UART
        load_line(0, "a\n");
        model_lines();
        run_drain(100, "pre_reset");
        busy_mode = 3;
        load_line(1, "7");
        wait_src(1, 20, "buffered_7");
        repeat (2) do_cycle();
        check("pre_reset_oen", 32'(ia.output_en), 32'd1);
        check("pre_reset_data", 32'(ia.output_data), 32'h37);
        check("pre_reset_owner", 32'(ia.grant_id), 32'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_oen", 32'(ia.output_en), 32'd0);
        check("async_rst_busy", 32'(ia.req_busy), 32'({NA{1'b1}}));
        check("async_rst_gv", 32'(ia.grant_valid), 32'd0);
        clear_src();
        model_rr = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        busy_mode = 1;
        load_line(0, "Y\n");
        load_line(1, "X\n");
        model_lines();
        run_drain(100, "post_reset");

        // Randomized line traffic
        max_gap = 3;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NA; i++) begin
                nl = $urandom_range(0, 3);
                for (int l = 0; l < nl; l++) begin
                    len = $urandom_range(1, 5);
                    for (int c = 0; c < len; c++) src_q[i].push_back(8'($urandom_range(8'h21, 8'h7E)));
                    src_q[i].push_back(8'h0A);
                end
            end
            model_lines();
            run_drain(2000, "random");
        end

        // TIMEOUT=0 instance with three requesters: no eviction, pointer wraps 2 -> 0
        @(negedge clk);
        ib.req_data = {8'h0A, 8'h0A, 8'h39};
        ib.req_en = 3'b111;
        @(negedge clk); #1;
        check("b_grant0_gv", 32'(ib.grant_valid), 32'd1);
        check("b_grant0_id", 32'(ib.grant_id), 32'd0);
        @(negedge clk); #1;
        check("b_9_oen", 32'(ib.output_en), 32'd1);
        check("b_9_data", 32'(ib.output_data), 32'h39);
        ib.req_en[0] = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        check("b_hold_gv", 32'(ib.grant_valid), 32'd1);
        check("b_hold_id", 32'(ib.grant_id), 32'd0);
        check("b_hold_busy", 32'(ib.req_busy), 32'h6);
        check("b_hold_oen", 32'(ib.output_en), 32'd0);
        check("b_hold_data", 32'(ib.output_data), 32'h39);
        ib.req_data[7:0] = 8'h0A;
        ib.req_en[0] = 1'b1;
        @(negedge clk); #1;
        check("b_nl_gv", 32'(ib.grant_valid), 32'd0);
        check("b_nl_data", 32'(ib.output_data), 32'h0A);
        ib.req_en[0] = 1'b0;
        @(negedge clk); #1;
        check("b_grant1_id", 32'(ib.grant_id), 32'd1);
        check("b_grant1_gv", 32'(ib.grant_valid), 32'd1);
        @(negedge clk); #1;
        check("b_line1_end", 32'(ib.grant_valid), 32'd0);
        ib.req_en[1] = 1'b0;
        @(negedge clk); #1;
        check("b_grant2_id", 32'(ib.grant_id), 32'd2);
        @(negedge clk); #1;
        check("b_line2_end", 32'(ib.grant_valid), 32'd0);
        ib.req_data[7:0] = 8'h5A;
        ib.req_en = 3'b011;
        @(negedge clk); #1;
        check("b_wrap_gv", 32'(ib.grant_valid), 32'd1);
        check("b_wrap_id", 32'(ib.grant_id), 32'd0);
        ib.req_en = '0;

        repeat (3) @(negedge clk);
        check("exp_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
